// File: rtl/demux_1_to_8_collector_if.sv
// Bus between the bit-select stream source and the 1-to-8 collector.
// The master drives the serial side, and the slave returns the assembled word.
interface demux_1_to_8_collector_if;
  logic       Din;
  logic       DinValid;
  logic [2:0] S;
  logic       AutoMode;
  logic       Clear;
  logic [7:0] Q;
  logic [7:0] Written;
  logic [7:0] Word;
  logic       Done;
  logic       Busy;
  logic       Err;

  modport master (
    output Din, DinValid, S, AutoMode, Clear,
    input  Q, Written, Word, Done, Busy, Err
  );

  modport slave (
    input  Din, DinValid, S, AutoMode, Clear,
    output Q, Written, Word, Done, Busy, Err
  );
endinterface

// File: rtl/demux_1_to_8_collector.sv
// Sequential 1-to-8 demux that rebuilds a serial bit stream into a byte.
// DEMUX_DUP_ERR_EN enables the sticky duplicate-write flag; without it, Err is tied to 0.
module demux_1_to_8_collector #(
  parameter int N_OUT = 8,
  parameter int SEL_W = 3
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  demux_1_to_8_collector_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [N_OUT-1:0] q_q, q_d;
  logic [N_OUT-1:0] written_q, written_d;
  logic [N_OUT-1:0] word_q, word_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic [1:0]       state_q, state_d;
  logic [SEL_W-1:0] pos_s;
  logic [N_OUT-1:0] wr_mask_s;
`ifdef DEMUX_DUP_ERR_EN
  logic             err_q, err_d;
`endif

  // Next-state: route the bit, track completion, handle abort
  always_comb begin
    q_d       = q_q;
    written_d = written_q;
    word_d    = word_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    state_d   = state_q;
`ifdef DEMUX_DUP_ERR_EN
    err_d     = err_q;
`endif
    pos_s     = bus.AutoMode ? cnt_q : bus.S;
    wr_mask_s = written_q | (N_OUT'(1) << pos_s);

    if (bus.Clear) begin
      // Abort drops any same-cycle write but keeps Q and Word intact
      written_d = '0;
      cnt_d     = '0;
      state_d   = IDLE;
`ifdef DEMUX_DUP_ERR_EN
      err_d     = 1'b0;
`endif
    end else if (bus.DinValid) begin
      q_d[pos_s] = bus.Din;
`ifdef DEMUX_DUP_ERR_EN
      if (!bus.AutoMode && written_q[pos_s]) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
`endif
      if (wr_mask_s == {N_OUT{1'b1}}) begin
        word_d    = q_d;
        done_d    = 1'b1;
        written_d = '0;
        cnt_d     = '0;
        state_d   = DONE;
      end else begin
        written_d = wr_mask_s;
        cnt_d     = bus.AutoMode ? cnt_q + SEL_W'(1) : cnt_q;
        state_d   = COLLECT;
      end
    end else begin
      if (state_q == DONE) begin
        state_d = IDLE;
      end else begin
        state_d = state_q;
      end
    end
    busy_d = (written_d != '0);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      q_q       <= '0;
      written_q <= '0;
      word_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      state_q   <= IDLE;
`ifdef DEMUX_DUP_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      q_q       <= q_d;
      written_q <= written_d;
      word_q    <= word_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
`ifdef DEMUX_DUP_ERR_EN
      err_q     <= err_d;
`endif
    end
  end

  assign bus.Q       = q_q;
  assign bus.Written = written_q;
  assign bus.Word    = word_q;
  assign bus.Done    = done_q;
  assign bus.Busy    = busy_q;
`ifdef DEMUX_DUP_ERR_EN
  assign bus.Err     = err_q;
`else
  assign bus.Err     = 1'b0;
`endif

endmodule

// File: tb/tb_demux_1_to_8_collector.sv
// Directed bench for demux_1_to_8_collector; the expected Err follows DEMUX_DUP_ERR_EN.
module tb_demux_1_to_8_collector;
  logic Clk;
  logic Reset_n;
  int   n_pass;
  int   n_total;

`ifdef DEMUX_DUP_ERR_EN
  localparam logic DUP = 1'b1;
`else
  localparam logic DUP = 1'b0;
`endif

  demux_1_to_8_collector_if bus ();

  demux_1_to_8_collector dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then let outputs settle 1 ns after the edge
  task automatic step(input logic din, input logic vld, input logic [2:0] s,
                      input logic auto_m, input logic clr);
    bus.Din      = din;
    bus.DinValid = vld;
    bus.S        = s;
    bus.AutoMode = auto_m;
    bus.Clear    = clr;
    @(posedge Clk);
    #1;
  endtask

  logic [7:0] auto_bits;
  logic [2:0] ext_seq [8];

  initial begin
    n_pass  = 0;
    n_total = 0;
    Reset_n = 1'b0;
    bus.Din = 1'b1; bus.DinValid = 1'b1; bus.S = 3'd0; bus.AutoMode = 1'b1; bus.Clear = 1'b0;
    @(negedge Clk);

    // Reset with DinValid held high
    step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
    check("rst_q",       bus.Q,       8'h00);
    check("rst_word",    bus.Word,    8'h00);
    check("rst_written", bus.Written, 8'h00);
    check("rst_done",    {7'd0, bus.Done}, 8'h00);
    check("rst_busy",    {7'd0, bus.Busy}, 8'h00);
    check("rst_err",     {7'd0, bus.Err},  8'h00);
    Reset_n = 1'b1;

    // Auto-mode word: 1,0,1,1,0,0,1,0 -> 8'h4D
    auto_bits = 8'b0100_1101;
    step(auto_bits[0], 1'b1, 3'd0, 1'b1, 1'b0);
    check("auto_q1",       bus.Q,       8'h01);
    check("auto_written1", bus.Written, 8'h01);
    check("auto_busy1",    {7'd0, bus.Busy}, 8'h01);
    for (int i = 1; i < 7; i++) step(auto_bits[i], 1'b1, 3'd0, 1'b1, 1'b0);
    check("auto_written7", bus.Written, 8'h7F);
    check("auto_done7",    {7'd0, bus.Done}, 8'h00);
    step(auto_bits[7], 1'b1, 3'd0, 1'b1, 1'b0);
    check("auto_word",     bus.Word,    8'h4D);
    check("auto_done",     {7'd0, bus.Done}, 8'h01);
    check("auto_written0", bus.Written, 8'h00);
    check("auto_busy0",    {7'd0, bus.Busy}, 8'h00);
    check("auto_qhold",    bus.Q,       8'h4D);
    step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    check("auto_done_once", {7'd0, bus.Done}, 8'h00);
    check("auto_err",       {7'd0, bus.Err},  8'h00);

    // External out-of-order word with a rewrite of position 3
    ext_seq = '{3'd7, 3'd3, 3'd0, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4};
    step(1'b1, 1'b1, ext_seq[0], 1'b0, 1'b0);
    step(1'b1, 1'b1, ext_seq[1], 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
    check("ext_rewrite_written", bus.Written, 8'h88);
    check("ext_rewrite_err",     {7'd0, bus.Err}, {7'd0, DUP});
    for (int i = 2; i < 7; i++) step(1'b1, 1'b1, ext_seq[i], 1'b0, 1'b0);
    check("ext_written7", bus.Written, 8'hEF);
    check("ext_no_early_done", {7'd0, bus.Done}, 8'h00);
    step(1'b1, 1'b1, ext_seq[7], 1'b0, 1'b0);
    check("ext_word", bus.Word, 8'hFF);
    check("ext_done", {7'd0, bus.Done}, 8'h01);

    // Clear mid-word: the write in the Clear cycle is dropped
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'd0, 1'b1, 1'b0);
    check("clr_pre_q",       bus.Q,       8'hF0);
    check("clr_pre_written", bus.Written, 8'h0F);
    check("clr_err_sticky",  {7'd0, bus.Err}, {7'd0, DUP});
    step(1'b0, 1'b1, 3'd0, 1'b1, 1'b1);
    check("clr_written", bus.Written, 8'h00);
    check("clr_busy",    {7'd0, bus.Busy}, 8'h00);
    check("clr_q",       bus.Q,       8'hF0);
    check("clr_done",    {7'd0, bus.Done}, 8'h00);
    check("clr_word",    bus.Word,    8'hFF);
    check("clr_err",     {7'd0, bus.Err}, 8'h00);
    auto_bits = 8'b1010_1010;
    for (int i = 0; i < 8; i++) step(auto_bits[i], 1'b1, 3'd0, 1'b1, 1'b0);
    check("clr_next_word", bus.Word, 8'hAA);
    check("clr_next_done", {7'd0, bus.Done}, 8'h01);

    // Back-to-back: write during the DONE cycle
    step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
    check("b2b_done",    {7'd0, bus.Done}, 8'h00);
    check("b2b_written", bus.Written, 8'h01);
    check("b2b_busy",    {7'd0, bus.Busy}, 8'h01);
    check("b2b_q",       bus.Q,       8'hAB);
    check("b2b_word",    bus.Word,    8'hAA);

    // Duplicate external write to position 2
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
    check("dup_first_err", {7'd0, bus.Err}, 8'h00);
    step(1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    check("dup_err",     {7'd0, bus.Err}, {7'd0, DUP});
    check("dup_q",       bus.Q,       8'hAB & 8'hFB);
    check("dup_written", bus.Written, 8'h04);
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    check("dup_err_hold", {7'd0, bus.Err}, {7'd0, DUP});
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    check("dup_err_clr", {7'd0, bus.Err}, 8'h00);

    // Reset in the middle of a word
    step(1'b1, 1'b1, 3'd6, 1'b0, 1'b0);
    Reset_n = 1'b0;
    step(1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
    check("midrst_written", bus.Written, 8'h00);
    check("midrst_q",       bus.Q,       8'h00);
    check("midrst_word",    bus.Word,    8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/demux_1_to_8_collector.md
Name: demux_1_to_8_collector

Overview:
- Sequential 1-to-8 demultiplexer. It is the receive end of the 8-to-1 bit-select path.
- Routes a serial bit onto one of eight held output positions, selected by either the 3-bit select line or an internal counter.
- When all eight positions have been written, the assembled byte is published with a one-cycle Done pulse.
- Sits on the processor datapath wherever a muxed single-bit stream must be rebuilt into a parallel word.

Parameters:
- N_OUT, 8, number of output positions; fixed at 8 in this revision.
- SEL_W, 3, select width; equals log2(N_OUT).

Ports:
- Clk  input  1  rising-edge clock, single clock domain.
- Reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of Clk.
- Din  input  1  serial data bit.
- DinValid  input  1  Din is written this cycle when high.
- S  input  3  target position in external mode.
- AutoMode  input  1  1 = internal counter selects the position; 0 = S selects it.
- Clear  input  1  synchronous abort of the current word.
- Q  output  8  live demux outputs; Q[k] holds the last bit written to position k.
- Written  output  8  per-position written mask for the current word.
- Word  output  8  completed byte, updated only at completion.
- Done  output  1  one-cycle pulse, coincident with the Word update.
- Busy  output  1  high while a word is partially collected.
- Err  output  1  duplicate-write flag (see Optional Feature).

Behaviour:
- Reset (Reset_n=0 at a clock edge):
  - Q, Written, Word = 8'h00.
  - Done, Busy, Err = 0.
  - Internal counter Cnt = 0; state = IDLE.
  - Reset overrides every other input, including in the middle of a word.
- States:
  - IDLE: Written = 0.
  - COLLECT: 0 < popcount(Written) < 8.
  - DONE: single cycle.
- Position select: pos = AutoMode ? Cnt : S. AutoMode is sampled each cycle.
- Write (DinValid=1, Clear=0):
  - Q[pos] <= Din and Written[pos] <= 1 at the next edge. Write latency is 1 cycle.
  - All other Q bits hold.
- Auto mode: Cnt increments after each write and wraps from 7 to 0 on completion.
- External mode:
  - Cnt holds its value.
  - Positions may be written in any order.
  - A rewrite of an already-written position overwrites Q[pos] and does not advance completion.
- Transitions:
  - IDLE -> COLLECT on the first write.
  - COLLECT -> DONE at the edge where the write makes Written == 8'hFF.
- On entering DONE, in the same edge:
  - Word <= the completed Q value, including the final bit.
  - Done = 1 for exactly one cycle.
  - Written <= 0 and Cnt <= 0.
  - State returns to IDLE at the next edge.
  - Q is not cleared.
- Write during the DONE cycle: accepted as the first bit of the next word. Written becomes a single bit, state goes to COLLECT, and Done still deasserts.
- Busy = (Written != 0).
- Clear=1:
  - Written <= 0, Cnt <= 0, state <= IDLE.
  - Q and Word hold.
  - Any write in the same cycle is dropped.
  - Done never pulses on a Clear cycle.
- Mode change mid-word: permitted. Written is not reset. Completion is always judged by Written == 8'hFF.
- DinValid=0: no state change other than a Clear or DONE exit.
- X on Din while DinValid=0: ignored.

Optional Feature:
- Macro: DEMUX_DUP_ERR_EN.
- Defined:
  - Err is set to 1 when an external-mode write targets a position whose Written bit is already 1.
  - Err is sticky until Reset_n=0 or Clear=1.
  - The write itself still proceeds.
- Undefined: Err is tied to 0 and no detection logic is built.

Test Plan:
- Reset check: hold Reset_n=0 for 2 cycles with DinValid=1 -> Q=00, Word=00, Written=00, Done=0, Busy=0.
- Auto-mode word: AutoMode=1, stream Din=1,0,1,1,0,0,1,0 on 8 consecutive valid cycles:
  - Q[k] = k-th bit, so Word=8'h4D (Q[0]=1).
  - Done pulses once, on the edge after the 8th bit.
  - Written returns to 00.
- External out-of-order word: S=7,3,0,5,1,6,2,4 with Din=1 for all -> Word=8'hFF and Done=1 after the 8th write. Also verify that an earlier rewrite of S=3 does not trigger Done prematurely.
- Clear mid-word: write 4 bits, then assert Clear -> Written=00, Busy=0, Q holds, no Done. The next 8 writes complete normally.
- Back-to-back words: write during the DONE cycle -> Done pulses once, and the new word starts with Written having a single bit set.
- With DEMUX_DUP_ERR_EN defined: external write S=2 twice -> Err=1 and stays high until Clear. With the macro undefined, the same stimulus leaves Err=0.
